bus_dev_port: RTL
=================

# bus_dev_port

Device-side endpoint for one port of the `bs_gnrtr_n_rbtr` bus. It buffers outbound packets in a TX FIFO that the arbiter drains through `pndng`/`pop`/`D_pop`. It accepts inbound packets from `push`/`D_push`, filters them by destination ID, and queues them in an RX FIFO for the local consumer. One instance sits between each device and its bus port, in place of the behavioural FIFO model used by the bench driver.

## Interface
- `pckg_sz`, 16: packet width in bits. Bits [pckg_sz-1 -: 8] hold the destination ID.
- `depth`, 8: entries per FIFO. Must be a power of two, ≥2.
- `id`, 0: this device's 8-bit address.
- `broadcast`, 8'hFF: broadcast destination ID.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `tx_push` in 1: local write strobe into the TX FIFO.
- `tx_data` in pckg_sz: packet to send.
- `tx_full` out 1: TX FIFO full.
- `pndng` out 1: TX FIFO non-empty (to arbiter).
- `D_pop` out pckg_sz: TX FIFO head (to arbiter).
- `pop` in 1: arbiter consumes the TX head.
- `push` in 1: arbiter delivers a packet.
- `D_push` in pckg_sz: delivered packet.
- `rx_pndng` out 1: RX FIFO non-empty.
- `rx_data` out pckg_sz: RX FIFO head.
- `rx_pop` in 1: local consumer takes the RX head.
- `rx_ovf_cnt` out 8: inbound packets dropped because the RX FIFO was full. Saturates at 255.
- `rx_miss_cnt` out 8: inbound packets dropped on destination mismatch. Saturates at 255.

## Operation
- Both FIFOs are first-word-fall-through: the head is always driven from storage and is stable while the FIFO is non-empty.
- **TX path**
  - `tx_push` with not full: write `tx_data`.
  - `pop` with `pndng`: advance the head.
  - `pop` while empty: ignored, no state change.
  - `tx_push` while full and without `pop`: dropped (local writer must honour `tx_full`).
  - Full FIFO, `tx_push` and `pop` together: both take effect, count unchanged.
- **RX filter**
  - A `push` is accepted when `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`.
  - Otherwise `rx_miss_cnt` increments.
- **RX enqueue**
  - Accepted packet with RX not full: write the packet.
  - Accepted packet with RX full: the packet is dropped and `rx_ovf_cnt` increments. This applies even if `rx_pop` is asserted in the same cycle; the bus side gets no backpressure, so the drop rule is fixed.
  - `rx_pop` while empty: ignored.
- **Empty FIFO, write and read in the same cycle:** the write happens and the read is ignored. There is no bypass.
- **Pointers:** log2(depth)+1 bits wide. The MSB distinguishes full from empty, and pointers wrap modulo 2·depth.
- **Reset:** asynchronous assertion clears pointers and counters immediately, mid-operation included.
  - Reset values: `pndng`=0, `tx_full`=0, `rx_pndng`=0, both counters 0.
  - `D_pop`/`rx_data` read as 0, because storage is cleared.
  - Release is synchronous to `clk` and takes effect on the first rising edge after deassertion.

## Timing
- A write on edge N makes `pndng`/`rx_pndng` high from edge N until the entry is read.
- Push-to-bus latency is 1 cycle.
- A read on edge N presents the next head from edge N.
- Flags and counters are registered, with no combinational path from inputs to outputs.
- `D_push` is sampled only on edges where `push`=1.
- Counter increments are visible 1 cycle after the offending `push`.

## Structure
- **Package `bus_pkg`:**
  - `ADDR_W`=8.
  - Default `BROADCAST`=8'hFF.
  - Function `dest_of(pkt)` returning the top 8 bits.
- **Sub-module `fifo_sync #(width, depth)`:**
  - Ports: `clk`, `reset`, `wr`, `din`, `rd`, `dout`, `full`, `empty`.
  - Instantiated twice, once for TX and once for RX.
- The filter and counters live in the top module.

## Test plan
1. Reset held low → `pndng`=0, `tx_full`=0, `rx_pndng`=0, counters 0. Pulse `reset` low for 3 ns mid-cycle with 3 entries queued → flags clear immediately, before the next edge.
2. `tx_push` 16'h0A11, 16'h0B22, 16'h0C33 → `pndng`=1 after the first edge and `D_pop`=16'h0A11. Three `pop`s → 0A11, 0B22, 0C33 in order, then `pndng`=0. A 4th `pop` changes nothing.
3. Fill TX with 8 entries → `tx_full`=1. A 9th `tx_push` alone is dropped. 9th `tx_push`+`pop` together → FIFO stays at 8 and the new packet appears at the tail.
4. `id`=2: `push` 16'h0255 and 16'hFF66 → both reach RX in order. `push` 16'h0377 → not queued, `rx_miss_cnt`=1.
5. Fill RX with 8 entries, then `push` 16'h0299 with `rx_pop` in the same cycle → packet dropped, `rx_ovf_cnt`=1. Drive 300 overflows → counter holds at 255.
6. Run 20 cycles of random `tx_push`/`pop` and `push`/`rx_pop` crossing pointer wrap → scoreboard order matches and no flag glitches.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus device endpoint: address width, the
// broadcast ID, the inbound-packet verdict type and the destination extractor.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] BROADCAST = 8'hFF;

    // Widest packet the destination helper can take; narrower packets are zero-extended.
    localparam int PKT_MAX = 64;

    // What happens to an inbound packet on a given cycle.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_ACCEPT = 2'd1,
        RX_MISS   = 2'd2,
        RX_OVF    = 2'd3
    } rx_verdict_t;

    // Destination ID lives in the top ADDR_W bits of a pkt_w-bit packet.
    function automatic logic [ADDR_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                                  input int unsigned pkt_w);
        return pkt[pkt_w-1 -: ADDR_W];
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO. The head is read straight from
// storage, pointers carry one extra wrap bit to tell full from empty, and an
// asynchronous active-low reset clears pointers and storage.
module fifo_sync #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] din,
    input  logic             rd,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             rd_en;
    logic             wr_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A read of an empty FIFO is ignored, so a same-cycle write is never bypassed.
    assign rd_en = rd && !empty;
    // A full FIFO still takes a write when a read frees the head slot that cycle.
    assign wr_en = wr && (!full || rd_en);

    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage: cleared on reset so the head reads as zero, written at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointers advance modulo 2*depth on accepted writes and reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: a TX FIFO drained by the arbiter, plus an inbound
// filter on destination ID feeding an RX FIFO, with saturating drop counters.
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int                pckg_sz   = 16,
    parameter int                depth     = 8,
    parameter logic [ADDR_W-1:0] id        = 8'h00,
    parameter logic [ADDR_W-1:0] broadcast = BROADCAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_pndng,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_pop,
    output logic [7:0]         rx_ovf_cnt,
    output logic [7:0]         rx_miss_cnt
);

    logic              tx_empty;
    logic              rx_empty;
    logic              rx_full;
    logic              rx_wr;
    logic [ADDR_W-1:0] push_dest;
    logic              dest_hit;
    rx_verdict_t       verdict;
    logic [7:0]        ovf_cnt_reg;
    logic [7:0]        miss_cnt_reg;

    fifo_sync #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_push),
        .din   (tx_data),
        .rd    (pop),
        .dout  (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign pndng = !tx_empty;

    assign push_dest = dest_of(PKT_MAX'(D_push), pckg_sz);
    assign dest_hit  = (push_dest == id) || (push_dest == broadcast);

    // Classify the inbound packet; a full RX drops even if the consumer pops this cycle.
    always_comb begin
        verdict = RX_IDLE;
        if (push) begin
            if (!dest_hit) begin
                verdict = RX_MISS;
            end else if (rx_full) begin
                verdict = RX_OVF;
            end else begin
                verdict = RX_ACCEPT;
            end
        end
    end

    assign rx_wr = (verdict == RX_ACCEPT);

    fifo_sync #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .din   (D_push),
        .rd    (rx_pop),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_pndng = !rx_empty;

    // Saturating drop counters for overflow and destination mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (verdict == RX_OVF && ovf_cnt_reg != 8'hFF) begin
                ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
            end
            if (verdict == RX_MISS && miss_cnt_reg != 8'hFF) begin
                miss_cnt_reg <= miss_cnt_reg + 8'd1;
            end
        end
    end

    assign rx_ovf_cnt  = ovf_cnt_reg;
    assign rx_miss_cnt = miss_cnt_reg;

endmodule
